// File: rtl/hyper_pkg.sv
// Shared types and defaults for the hyper event router.
package hyper_pkg;

    typedef enum logic {
        DIR_WRITE = 1'b0,
        DIR_READ  = 1'b1
    } dir_e;

    localparam int unsigned HYPER_NB_CH      = 2;
    localparam int unsigned HYPER_FIFO_DEPTH = 4;

endpackage

// File: rtl/udma_hyper_dir_queue.sv
// One channel: in-order direction queue, up to two pushes (WRITE then READ)
// and one pop per cycle, with registered done pulses and sticky error flags.
module udma_hyper_dir_queue
    import hyper_pkg::*;
#(
    parameter  int unsigned DEPTH = HYPER_FIFO_DEPTH,
    localparam int unsigned AW    = $clog2(DEPTH),
    localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk_i,
    input  logic          rstn_i,
    input  logic          tx_i,
    input  logic          rx_i,
    input  logic          eot_i,
    input  logic          clr_i,
    output logic          rd_done_o,
    output logic          wr_done_o,
    output logic [CW-1:0] count_o,
    output logic          ovf_o,
    output logic          unexp_o
);

    dir_e          mem_q [DEPTH];
    dir_e          mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d;
    logic          unexp_q, unexp_d;
    logic          rd_done_q, rd_done_d;
    logic          wr_done_q, wr_done_d;

    logic          pop;
    logic [CW:0]   free_slots;
    logic [1:0]    n_req;
    logic [1:0]    n_acc;
    dir_e          first_dir;

    always_comb begin
        pop        = eot_i && (count_q != '0);
        // A pop in the same cycle frees a slot for an incoming push.
        free_slots = (CW+1)'(DEPTH) - {1'b0, count_q} + (CW+1)'(pop);
        n_req      = {1'b0, tx_i} + {1'b0, rx_i};
        n_acc      = ((CW+1)'(n_req) > free_slots) ? free_slots[1:0] : n_req;
        first_dir  = tx_i ? DIR_WRITE : DIR_READ;

        mem_d = mem_q;
        if (n_acc != 2'd0) mem_d[wr_ptr_q]         = first_dir;
        if (n_acc == 2'd2) mem_d[wr_ptr_q + 1'b1]  = DIR_READ;

        wr_ptr_d  = wr_ptr_q + AW'(n_acc);
        rd_ptr_d  = rd_ptr_q + AW'(pop);
        count_d   = count_q + CW'(n_acc) - CW'(pop);
        ovf_d     = ovf_q | (n_req != n_acc);
        unexp_d   = unexp_q | (eot_i && (count_q == '0));
        rd_done_d = pop && (mem_q[rd_ptr_q] == DIR_READ);
        wr_done_d = pop && (mem_q[rd_ptr_q] == DIR_WRITE);

        // Flush beats every push/pop of the same cycle, including its done pulse.
        if (clr_i) begin
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            count_d   = '0;
            ovf_d     = 1'b0;
            unexp_d   = 1'b0;
            rd_done_d = 1'b0;
            wr_done_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            ovf_q     <= 1'b0;
            unexp_q   <= 1'b0;
            rd_done_q <= 1'b0;
            wr_done_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            ovf_q     <= ovf_d;
            unexp_q   <= unexp_d;
            rd_done_q <= rd_done_d;
            wr_done_q <= wr_done_d;
        end
    end

    // Storage is never read beyond count_q, so it carries no reset.
    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
    end

    assign rd_done_o = rd_done_q;
    assign wr_done_o = wr_done_q;
    assign count_o   = count_q;
    assign ovf_o     = ovf_q;
    assign unexp_o   = unexp_q;

endmodule

// File: rtl/udma_hyper_evt_router.sv
// Routes uDMA launch / hyper end-of-transfer events per channel into
// read-done and write-done pulses, one independent queue per channel.
module udma_hyper_evt_router
    import hyper_pkg::*;
#(
    parameter  int unsigned NB_CH      = HYPER_NB_CH,
    parameter  int unsigned FIFO_DEPTH = HYPER_FIFO_DEPTH,
    localparam int unsigned CW         = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                      sys_clk_i,
    input  logic                      rstn_i,
    input  logic [NB_CH-1:0]          rx_evt_i,
    input  logic [NB_CH-1:0]          tx_evt_i,
    input  logic [NB_CH-1:0]          eot_i,
    input  logic [NB_CH-1:0]          clr_i,
    output logic [NB_CH-1:0]          rd_done_o,
    output logic [NB_CH-1:0]          wr_done_o,
    output logic [NB_CH-1:0][CW-1:0]  count_o,
    output logic [NB_CH-1:0]          ovf_o,
    output logic [NB_CH-1:0]          unexp_o
);

    for (genvar ch = 0; ch < NB_CH; ch++) begin : g_ch
        udma_hyper_dir_queue #(
            .DEPTH (FIFO_DEPTH)
        ) u_queue (
            .clk_i     (sys_clk_i),
            .rstn_i    (rstn_i),
            .tx_i      (tx_evt_i[ch]),
            .rx_i      (rx_evt_i[ch]),
            .eot_i     (eot_i[ch]),
            .clr_i     (clr_i[ch]),
            .rd_done_o (rd_done_o[ch]),
            .wr_done_o (wr_done_o[ch]),
            .count_o   (count_o[ch]),
            .ovf_o     (ovf_o[ch]),
            .unexp_o   (unexp_o[ch])
        );
    end

endmodule
